// File: rtl/wb_arbiter.sv
// wb_arbiter: merges ALU results and queued load results onto one registered
// register-file write port, with a bounded wait for queued loads.
module wb_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid,
    input  logic [4:0]               alu_waddr,
    input  logic [31:0]              alu_wdata,
    output logic                     alu_stall,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [4:0]               mem_waddr,
    input  logic [31:0]              mem_wdata,
    output logic                     we,
    output logic [4:0]               waddr,
    output logic [31:0]              wdata,
    input  logic [4:0]               chk_addr,
    output logic                     chk_pending,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]    fifo_addr_q [DEPTH];
    logic [31:0]   fifo_data_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    starve_q, starve_d;
    logic          we_q, we_d;
    logic [4:0]    waddr_q, waddr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          alu_eff, fifo_ne, grant_fifo, push, pop;

    // Load handshake: a transfer happens on a rising edge where mem_valid and
    // mem_ready are both high; mem_ready depends only on registered occupancy.
    assign fifo_ne    = (count_q != '0);
    assign alu_stall  = (starve_q == 8'(STARVE_LIMIT));
    assign mem_ready  = !rst && (count_q < CW'(DEPTH));
    assign alu_eff    = alu_valid && (alu_waddr != 5'd0) && !alu_stall;
    assign grant_fifo = fifo_ne && !alu_eff;
    assign pop        = grant_fifo;
    assign push       = mem_valid && mem_ready && (mem_waddr != 5'd0);

    always_comb begin
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (alu_eff) begin
            we_d    = 1'b1;
            waddr_d = alu_waddr;
            wdata_d = alu_wdata;
        end else if (grant_fifo) begin
            we_d    = 1'b1;
            waddr_d = fifo_addr_q[rd_ptr_q];
            wdata_d = fifo_data_q[rd_ptr_q];
        end
    end

    always_comb begin
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    // The counter only runs while a head exists and keeps losing to the ALU.
    always_comb begin
        starve_d = starve_q;
        if (pop || !fifo_ne) begin
            starve_d = '0;
        end else if (starve_q != 8'(STARVE_LIMIT)) begin
            starve_d = starve_q + 8'd1;
        end
    end

    always_comb begin
        chk_pending = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (({1'b0, AW'(AW'(i) - rd_ptr_q)} < count_q) &&
                (fifo_addr_q[i] == chk_addr) && (chk_addr != 5'd0)) begin
                chk_pending = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    // Entry storage needs no reset; validity comes from the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= mem_waddr;
            fifo_data_q[wr_ptr_q] <= mem_wdata;
        end
    end

    assign we         = we_q;
    assign waddr      = waddr_q;
    assign wdata      = wdata_q;
    assign fifo_count = count_q;
endmodule
